// File: rtl/vga_scroll_fetch.sv
// vga_scroll_fetch: pixel-source stage feeding vga_ctrl.
// Maps scan coordinates to read addresses in a 512x512 12-bit image ROM. The
// image is tiled over the screen and scrolled by per-frame X/Y offsets. The
// scan column is advanced by LOOKAHEAD so that the returned colour word lines
// up with the pixel being scanned, after the address register, the ROM and
// the output register.
module vga_scroll_fetch #(
    parameter int          LOOKAHEAD = 3,
    parameter int          STEP      = 4,
    parameter int          AUTO_STEP = 1,
    parameter logic [11:0] BORDER    = 12'h000
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        vsync,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        auto_en,
    output logic [17:0] rom_addr,
    input  logic [11:0] rom_q,
    output logic [11:0] vga_data,
    output logic [8:0]  sx,
    output logic [8:0]  sy,
    output logic [15:0] frame_cnt
);

    // Registered state
    logic        vsync_q;
    logic [17:0] rom_addr_q;
    logic        oob1_q;
    logic        oob2_q;
    logic [11:0] vga_data_q;
    logic [8:0]  sx_q;
    logic [8:0]  sy_q;
    logic [15:0] frame_cnt_q;

    // Next-state values
    logic [17:0] rom_addr_d;
    logic        oob1_d;
    logic [11:0] vga_data_d;
    logic [8:0]  sx_d;
    logic [8:0]  sy_d;
    logic [15:0] frame_cnt_d;

    // Combinational helpers
    logic        tick_s;
    logic [10:0] xt_s;
    logic [8:0]  row_s;
    logic [8:0]  col_s;

    // Rows never reach 512 in the active area, so v_addr[9] carries no data.
    logic        unused_vbit_s;
    assign unused_vbit_s = v_addr[9];

    // Frame tick: one pulse on the falling edge of the active-low vsync.
    assign tick_s = vsync_q & ~vsync;

    // Stage 1 address generation: look-ahead column, border flag, tiled/scrolled address.
    always_comb begin
        xt_s       = {1'b0, h_addr} + 11'(LOOKAHEAD);
        row_s      = v_addr[8:0] + sy_q;
        col_s      = xt_s[8:0] + sx_q;
        oob1_d     = (xt_s >= 11'd640);
        rom_addr_d = {row_s, col_s};
    end

    // Stage 3 colour select: border outside the visible columns, ROM word otherwise.
    always_comb begin
        vga_data_d = rom_q;
        if (oob2_q) begin
            vga_data_d = BORDER;
        end else begin
            vga_data_d = rom_q;
        end
    end

    // Scroll offsets and frame counter: update only on the frame tick, wrap mod 512.
    always_comb begin
        sx_d        = sx_q;
        sy_d        = sy_q;
        frame_cnt_d = frame_cnt_q;
        if (tick_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (auto_en) begin
                sx_d = sx_q + 9'(AUTO_STEP);
                sy_d = sy_q;
            end else begin
                case ({btn_left, btn_right})
                    2'b10:   sx_d = sx_q - 9'(STEP);
                    2'b01:   sx_d = sx_q + 9'(STEP);
                    default: sx_d = sx_q;
                endcase
                case ({btn_up, btn_down})
                    2'b10:   sy_d = sy_q - 9'(STEP);
                    2'b01:   sy_d = sy_q + 9'(STEP);
                    default: sy_d = sy_q;
                endcase
            end
        end else begin
            sx_d        = sx_q;
            sy_d        = sy_q;
            frame_cnt_d = frame_cnt_q;
        end
    end

    // All state: pipeline registers, vsync edge detector, offsets and frame count.
    always_ff @(posedge pclk) begin
        if (reset) begin
            vsync_q     <= 1'b1;
            rom_addr_q  <= 18'd0;
            oob1_q      <= 1'b0;
            oob2_q      <= 1'b0;
            vga_data_q  <= 12'd0;
            sx_q        <= 9'd0;
            sy_q        <= 9'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            vsync_q     <= vsync;
            rom_addr_q  <= rom_addr_d;
            oob1_q      <= oob1_d;
            oob2_q      <= oob1_q;
            vga_data_q  <= vga_data_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign vga_data  = vga_data_q;
    assign sx        = sx_q;
    assign sy        = sy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_scroll_fetch.sv
// Testbench for vga_scroll_fetch: randomized scan/button stimulus against a
// plain-arithmetic reference model, with a scoreboard queue for pixel data.
module tb_vga_scroll_fetch;

    localparam logic [11:0] BORDER = 12'h000;

    logic        pclk = 1'b0;
    logic        reset;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        vsync;
    logic        btn_left;
    logic        btn_right;
    logic        btn_up;
    logic        btn_down;
    logic        auto_en;
    logic [17:0] rom_addr;
    logic [11:0] rom_q;
    logic [11:0] vga_data;
    logic [8:0]  sx;
    logic [8:0]  sy;
    logic [15:0] frame_cnt;

    typedef struct {
        bit          valid;
        logic [11:0] exp;
        int          h;
        int          v;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int msx = 0;
    int msy = 0;
    int mfc = 0;
    bit mvs = 1'b1;
    bit state_chk = 1'b0;

    always #20 pclk = ~pclk;

    vga_scroll_fetch #(
        .LOOKAHEAD(3), .STEP(4), .AUTO_STEP(1), .BORDER(BORDER)
    ) dut (
        .pclk(pclk), .reset(reset), .h_addr(h_addr), .v_addr(v_addr),
        .vsync(vsync), .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down), .auto_en(auto_en),
        .rom_addr(rom_addr), .rom_q(rom_q), .vga_data(vga_data),
        .sx(sx), .sy(sy), .frame_cnt(frame_cnt)
    );

    // Image content: mixes row bits into the word so that every address bit matters.
    function automatic logic [11:0] rom_fn(input logic [17:0] a);
        return a[11:0] ^ {a[17:12], a[17:12]};
    endfunction

    // Registered-address ROM model
    always @(posedge pclk) rom_q <= rom_fn(rom_addr);

    function automatic logic [11:0] exp_pix(input int h, input int v, input int ox, input int oy);
        int xt;
        int row;
        int col;
        xt = h + 3;
        if (xt >= 640) return BORDER;
        row = ((v % 512) + oy) % 512;
        col = ((xt % 512) + ox) % 512;
        return rom_fn(18'(row * 512 + col));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: vga_data for an issued cycle appears three edges later.
    always @(negedge pclk) begin
        if (sb.size() >= 4) begin
            mon_e = sb.pop_front();
            if (mon_e.valid)
                check($sformatf("pixel h=%0d v=%0d", mon_e.h, mon_e.v), 32'(vga_data), 32'(mon_e.exp));
        end
    end

    // One clock of stimulus; called #1 after a rising edge.
    task automatic step(input int h, input int v, input bit vs, input bit bl, input bit br,
                        input bit bu, input bit bd, input bit ae, input bit rs);
        sb_t e;
        int n;
        int dx;
        int dy;
        if (state_chk) begin
            check("sx", 32'(sx), 32'(msx));
            check("sy", 32'(sy), 32'(msy));
            check("frame_cnt", 32'(frame_cnt), 32'(mfc));
        end
        h_addr = 10'(h); v_addr = 10'(v); vsync = vs;
        btn_left = bl; btn_right = br; btn_up = bu; btn_down = bd;
        auto_en = ae; reset = rs;
        e.valid = !rs;
        e.exp   = exp_pix(h, v, msx, msy);
        e.h     = h;
        e.v     = v;
        sb.push_back(e);
        if (rs) begin
            n = sb.size();
            for (int i = n - 3; i < n - 1; i++)
                if (i >= 0) sb[i].valid = 1'b0;
            msx = 0; msy = 0; mfc = 0; mvs = 1'b1;
        end else begin
            if (mvs && !vs) begin
                mfc = (mfc + 1) % 65536;
                if (ae) begin
                    msx = (msx + 1) % 512;
                end else begin
                    dx = (br ? 4 : 0) - (bl ? 4 : 0);
                    dy = (bd ? 4 : 0) - (bu ? 4 : 0);
                    msx = (msx + dx + 512) % 512;
                    msy = (msy + dy + 512) % 512;
                end
            end
            mvs = vs;
        end
        state_chk = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // Random scan cycles (vsync high, random buttons that must be ignored), then a tick.
    task automatic frame(input bit bl, input bit br, input bit bu, input bit bd,
                         input bit ae, input int n_scan);
        for (int i = 0; i < n_scan; i++)
            step($urandom_range(0, 799), $urandom_range(0, 524), 1'b1,
                 rb(), rb(), rb(), rb(), rb(), 1'b0);
        step($urandom_range(0, 799), $urandom_range(0, 524), 1'b0, bl, br, bu, bd, ae, 1'b0);
        step($urandom_range(0, 799), $urandom_range(0, 524), 1'b0, rb(), rb(), rb(), rb(), rb(), 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; h_addr = 10'd0; v_addr = 10'd0; vsync = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        auto_en = 1'b0;
        @(posedge pclk);
        #1;

        // reset state
        do_reset(2);
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        check("reset vga_data", 32'(vga_data), 32'd0);
        check("reset sx", 32'(sx), 32'd0);
        check("reset sy", 32'(sy), 32'd0);
        check("reset frame_cnt", 32'(frame_cnt), 32'd0);
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("no tick on vsync high", 32'(frame_cnt), 32'd0);

        // alignment sweep on row 5
        for (int k = 0; k < 640; k++)
            step(k, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // underflow: btn_up from sy=0
        frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        check("underflow sy", 32'(sy), 32'd508);
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("row0 rom_addr row", 32'(rom_addr[17:9]), 32'd508);
        for (int k = 1; k < 8; k++)
            step(k, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // scroll right with wrap
        do_reset(2);
        for (int i = 0; i < 128; i++)
            frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        check("right wrap sx", 32'(sx), 32'd0);
        check("right wrap frame_cnt", 32'(frame_cnt), 32'd128);
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        check("right +1 sx", 32'(sx), 32'd4);

        // conflicting buttons
        frame(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2);
        check("conflict sx", 32'(sx), 32'd4);
        check("conflict sy", 32'(sy), 32'd4);

        // auto-scroll overrides buttons
        for (int i = 1; i <= 3; i++) begin
            frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1);
            check("auto sx", 32'(sx), 32'(4 + i));
            check("auto sy", 32'(sy), 32'd4);
        end

        // randomized frames
        for (int i = 0; i < 200; i++)
            frame(rb(), rb(), rb(), rb(), rb(), $urandom_range(1, 8));

        // reset mid-operation
        do_reset(1);
        for (int i = 0; i < 25; i++)
            frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        check("pre-reset sx", 32'(sx), 32'd100);
        check("pre-reset frame_cnt", 32'(frame_cnt), 32'd25);
        for (int k = 300; k < 310; k++)
            step(k, 20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(310, 20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mid reset sx", 32'(sx), 32'd0);
        check("mid reset frame_cnt", 32'(frame_cnt), 32'd0);
        for (int k = 311; k < 320; k++)
            step(k, 20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        check("first frame after reset", 32'(frame_cnt), 32'd1);

        // let the pipeline drain into the monitor
        for (int i = 0; i < 4; i++)
            step(i, 30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
